// File: rtl/mips_mem_loader.sv
// Host wrapper around Lite_MIPS. It streams in the instruction and data images, runs the core
// until halt, snapshots data memory, and streams the snapshot back out one word at a time.
module mips_mem_loader #(
  parameter int W  = 32,
  parameter int L  = 6,
  parameter int CC = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  input  logic [W-1:0]          pc_current,
  input  logic [W*(2**L)-1:0]   data_mem_out_wire,
  output logic [W*(2**L)-1:0]   inst_mem_in_wire,
  output logic [W*(2**L)-1:0]   data_mem_in_wire,
  output logic                  core_rst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_data,
  output logic                  done,
  output logic [W-1:0]          halt_cycles,
  output logic                  halt_forced
);
  localparam int N = 2**L;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [N-1:0][W-1:0]   r_inst, r_data, r_snap;
  logic [L:0]            r_idx;
  logic [W-1:0]          r_cnt;
  logic [L-1:0]          r_oidx;
  logic [W-1:0]          r_halt_cycles;
  logic                  r_halt_forced;

  logic [L-1:0] w_p, w_p1;
  logic         w_zpair, w_cclim, w_halt;
  logic         w_unused;

  // p1 is L bits wide, so PC N-1 pairs with word 0.
  assign w_p      = pc_current[L-1:0];
  assign w_p1     = w_p + L'(1);
  assign w_zpair  = (r_inst[w_p] == '0) && (r_inst[w_p1] == '0);
  assign w_cclim  = (r_cnt == W'(CC));
  assign w_halt   = w_zpair || w_cclim;
  assign w_unused = ^pc_current[W-1:L];

  assign inst_mem_in_wire = r_inst;
  assign data_mem_in_wire = r_data;
  assign in_ready         = (r_state == S_LOAD);
  assign core_rst         = (r_state != S_RUN);
  assign out_valid        = (r_state == S_DRAIN);
  assign done             = (r_state == S_DONE);
  assign out_data         = out_valid ? r_snap[r_oidx] : '0;
  assign halt_cycles      = r_halt_cycles;
  assign halt_forced      = r_halt_forced;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_LOAD;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_oidx        <= '0;
      r_inst        <= '0;
      r_data        <= '0;
      r_snap        <= '0;
      r_halt_cycles <= '0;
      r_halt_forced <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: if (in_valid) begin
          // The top bit of idx selects the instruction or the data image.
          if (!r_idx[L]) r_inst[r_idx[L-1:0]] <= in_data;
          else           r_data[r_idx[L-1:0]] <= in_data;
          r_idx <= r_idx + (L+1)'(1);
          if (&r_idx) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (w_halt) begin
            r_snap        <= data_mem_out_wire;
            r_halt_cycles <= r_cnt;
            r_halt_forced <= w_cclim && !w_zpair;
            r_oidx        <= '0;
            r_state       <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + W'(1);
          end
        end
        S_DRAIN: if (out_ready) begin
          r_oidx <= r_oidx + L'(1);
          if (&r_oidx) r_state <= S_DONE;
        end
        S_DONE:  ;
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mem_loader.sv
// Randomized bench for mips_mem_loader. A per-cycle reference model predicts the load image,
// the halt cycle and cause, and the drained snapshot.
module tb_mips_mem_loader;
  localparam int W = 32, L = 6, N = 64, CC = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, in_valid, out_ready;
  logic [W-1:0]   in_data, pc_current;
  logic [W*N-1:0] dmem;
  logic           in_ready, core_rst, out_valid, done, halt_forced;
  logic [W-1:0]   out_data, halt_cycles;
  logic [W*N-1:0] ibus, dbus;
  logic           b_in_ready, b_core_rst, b_out_valid, b_done, b_halt_forced;
  logic [W-1:0]   b_out_data, b_halt_cycles;
  logic [W*N-1:0] b_ibus, b_dbus;

  mips_mem_loader #(.W(W), .L(L), .CC(CC)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .pc_current(pc_current), .data_mem_out_wire(dmem), .inst_mem_in_wire(ibus),
    .data_mem_in_wire(dbus), .core_rst(core_rst), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .done(done), .halt_cycles(halt_cycles), .halt_forced(halt_forced));

  // Same stimulus, CC=3: used for the simultaneous-halt case.
  mips_mem_loader #(.W(W), .L(L), .CC(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .pc_current(pc_current), .data_mem_out_wire(dmem), .inst_mem_in_wire(b_ibus),
    .data_mem_in_wire(b_dbus), .core_rst(b_core_rst), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .done(b_done), .halt_cycles(b_halt_cycles), .halt_forced(b_halt_forced));

  int         n_chk = 0, n_fail = 0;
  logic [W-1:0] inst_m [N];
  logic [W-1:0] data_m [N];
  logic [W-1:0] snap_m [N];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int g = 0; g < N; g++) begin
      inst_m[g] = $urandom | 32'h1;
      data_m[g] = $urandom;
    end
  endtask

  task automatic chk_cleared();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_halt_cycles", halt_cycles, 0);
    chk("rst_halt_forced", halt_forced, 0);
    chk("rst_ibus_zero", |ibus, 0);
    chk("rst_dbus_zero", |dbus, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load(input bit toggle);
    int k = 0, cyc = 0;
    while (k < 2*N && cyc < 8*N) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = (k < N) ? inst_m[k] : data_m[k-N];
      chk("load_in_ready", in_ready, 1);
      chk("load_core_rst", core_rst, 1);
      @(posedge clk); #1;
      if (in_valid) k++;
      cyc++;
    end
    in_valid = 1'b0;
    if (k < 2*N) chk("load_timeout", k, 2*N);
    chk("post_load_in_ready", in_ready, 0);
    chk("post_load_core_rst", core_rst, 0);
    for (int g = 0; g < N; g++) begin
      chk("inst_img", ibus[g*W +: W], inst_m[g]);
      chk("data_img", dbus[g*W +: W], data_m[g]);
    end
  endtask

  // mode 0: pc = cycle count, mode 1: pc stuck at 63
  task automatic run(input int mode);
    int  c = 0, exp_cyc = -1;
    bit  halted = 0, exp_forced = 0, zp;
    int  p;
    while (!halted && c <= CC + 5) begin
      pc_current = (mode == 0) ? c : 63;
      for (int g = 0; g < N; g++) dmem[g*W +: W] = $urandom;
      p  = pc_current % N;
      zp = (inst_m[p] == 0) && (inst_m[(p+1) % N] == 0);
      chk("run_core_rst", core_rst, 0);
      if (zp || c == CC) begin
        halted = 1; exp_cyc = c; exp_forced = !zp;
        for (int g = 0; g < N; g++) snap_m[g] = dmem[g*W +: W];
      end
      @(posedge clk); #1;
      c++;
    end
    if (!halted) chk("run_timeout", 0, 1);
    for (int g = 0; g < N; g++) dmem[g*W +: W] = $urandom;
    chk("halt_cycles", halt_cycles, exp_cyc);
    chk("halt_forced", halt_forced, exp_forced);
    chk("halt_out_valid", out_valid, 1);
    chk("halt_core_rst", core_rst, 1);
  endtask

  task automatic drain(input bit toggle, input int rst_at);
    int o = 0, cyc = 0;
    bit was_rst = 0;
    while (o < N && cyc < 4*N && !was_rst) begin
      if (o == rst_at) begin
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_core_rst", core_rst, 1);
        chk("mid_rst_ibus", |ibus, 0);
        chk("mid_rst_dbus", |dbus, 0);
        chk("mid_rst_halt", halt_cycles, 0);
        was_rst = 1;
      end else begin
        out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
        chk("drain_valid", out_valid, 1);
        chk("drain_data", out_data, snap_m[o]);
        chk("drain_done", done, 0);
        @(posedge clk); #1;
        if (out_ready) o++;
        cyc++;
      end
    end
    out_ready = 1'b0;
    if (!was_rst) begin
      if (o < N) chk("drain_timeout", o, N);
      chk("done", done, 1);
      chk("done_out_valid", out_valid, 0);
      chk("done_core_rst", core_rst, 1);
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; pc_current = '0; dmem = '0;
    @(posedge clk); #1;

    // Load mapping, forced halt with the PC stepping over all-nonzero code
    do_reset();
    chk_cleared();
    for (int g = 0; g < N; g++) begin
      inst_m[g] = 32'h100 + g;
      data_m[g] = 32'h140 + g;
    end
    load(0);
    chk("inst5", ibus[5*W +: W], 32'h105);
    chk("data3", dbus[3*W +: W], 32'h143);
    run(0);
    drain(0, -1);

    // Zero-pair halt at pc=4, with backpressure on both streams
    do_reset();
    chk_cleared();
    fill_random();
    inst_m[4] = '0; inst_m[5] = '0;
    load(1);
    run(0);
    chk("zp_halt_cycles", halt_cycles, 4);
    drain(1, -1);

    // PC stuck at 63, all nonzero: the cycle limit forces the halt
    do_reset();
    fill_random();
    load(0);
    run(1);
    chk("cc_halt_cycles", halt_cycles, CC);
    chk("cc_halt_forced", halt_forced, 1);
    drain(0, -1);

    // PC stuck at 63 with inst[63]=inst[0]=0: the pair wraps and halts at once
    do_reset();
    fill_random();
    inst_m[63] = '0; inst_m[0] = '0;
    load(0);
    run(1);
    chk("wrap_halt_cycles", halt_cycles, 0);
    drain(0, -1);

    // Zero pair and the CC=3 limit both hold at cnt=3
    do_reset();
    fill_random();
    inst_m[3] = '0; inst_m[4] = '0;
    load(0);
    run(0);
    chk("sim_halt_cycles", b_halt_cycles, 3);
    chk("sim_halt_forced", b_halt_forced, 0);
    chk("sim_out_valid", b_out_valid, 1);
    drain(0, 10);

    // A full reload after the mid-drain reset completes normally
    fill_random();
    load(1);
    run(1);
    drain(1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
